lsu_multi_outstanding: RTL
==========================

Name: lsu_multi_outstanding

Overview:
- Parametrised successor to the single-request memory-stage LSU path: a load/store unit that keeps up to DEPTH bus transactions in flight on the req/gnt/valid data bus.
- Sits between the EX/MEM pipeline register and writeback.
- Returns responses strictly in order, with byte-lane steering, load sign/zero extension, in-band misalignment errors, and flush-kill of in-flight entries.

Parameters:
- DEPTH, 2, max in-flight entries (granted or misaligned, not yet popped); power of two, 2..8.
- ADDR_WIDTH, 32, request/bus address width.
- TAG_WIDTH, 4, opaque writeback tag carried with each request.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_wr  in  1  1=store, 0=load.
- req_dtype  in  2  0=byte, 1=half, 2=word (3 treated as word).
- req_unsigned  in  1  zero-extend load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_tag  in  TAG_WIDTH  rd tag.
- flush  in  1  kill all in-flight entries and any current request.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  writeback accepts.
- rsp_wr  out  1  entry was a store.
- rsp_rdata  out  32  extended load data (0 for stores/errors).
- rsp_tag  out  TAG_WIDTH  tag of entry.
- rsp_err  out  1  bus error.
- rsp_misaligned  out  1  misaligned access, no bus cycle issued.
- busy  out  1  any entry in flight.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_gnt  in  1  bus grant.
- data_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0).
- data_wdata  out  32  lane-replicated store data.
- data_be  out  4  byte enables.
- data_rdata  in  32  read data.
- data_valid  in  1  response beat (in grant order).
- data_error  in  1  qualifies data_valid.

Behaviour:
- Reset: all outputs 0; FIFO empty; cnt=0.
- Storage: circular FIFO of DEPTH entries {wr, dtype, unsigned, offset[1:0], tag, done, err, mis, kill, rdata}.
- Pointers: wptr, rptr, cptr (oldest not-done). cnt = occupancy 0..DEPTH.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- Bus request: data_req = req_valid & ~misaligned & ~flush & cnt<DEPTH. Combinational from inputs; held by upstream until gnt.
- Accept: req_ready = ~flush & cnt<DEPTH & (misaligned | data_gnt).
  - On accept, write entry at wptr.
  - Misaligned entries are written done=1, mis=1 with no bus cycle.
- Byte enables: be = byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111.
- Store data: data_wdata = byte {4{b}}, half {2{h}}, word as-is.
- Response capture: data_valid writes rdata/err into entry at cptr, sets done, and advances cptr past it and past any already-done misaligned entries.
  - data_valid with no granted entry outstanding is ignored (protocol violation; asserted in sim).
- Load extraction: shift rdata right 8*offset; extend bit 7/15 unless unsigned.
  - Bus error or store gives rdata=0.
- Output: rsp_valid = head done & ~kill. Pop on rsp_valid & rsp_ready.
  - Killed done heads pop silently, one per cycle.
- Flush:
  - Sets kill on every occupied entry.
  - Blocks the accept that cycle.
  - Granted transactions still complete on the bus; their responses are absorbed and dropped.
  - cnt is not cleared; it drains naturally.
- Simultaneous events:
  - Accept + pop same cycle: cnt unchanged.
  - Full + pop: req_ready stays 0 that cycle; cnt<DEPTH is evaluated on registered cnt.
  - data_valid in the grant cycle for the same request is illegal (bus guarantees ≥1 cycle latency).
- Latency: load granted in cycle N with data_valid in N+k gives rsp_valid in N+k+1 (registered rdata).
- busy = cnt!=0.
- Reset mid-operation: all state cleared immediately; late bus responses after reset are ignored via the no-outstanding rule.

Test Plan:
- LW at 0x100, gnt same cycle, data_valid+1 with 0xDEADBEEF -> rsp_valid one cycle later, rdata=0xDEADBEEF, tag echoed, err=0.
- LB at 0x103, rdata=0x80xxxxxx -> data_be=4'b1000, rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
- SH 0x1234 at 0x102 -> data_be=4'b1100, data_wdata=0x12341234, data_addr=0x100; rsp_wr=1.
- DEPTH=2, three back-to-back LW with data_valid delayed 3 cycles -> third req_ready=0 until first pop; responses in issue order.
- LH at 0x101 behind an outstanding LW -> no data_req for it; rsp_misaligned=1 returned after the LW response.
- Two LW granted, flush before any data_valid -> both data_valid absorbed, no rsp_valid, busy falls to 0; rsp_ready low for 5 cycles holds rsp stable.

Source files
------------

// File: rtl/lsu_multi_outstanding_if.sv
// Request, response and data-bus bundle for the multi-outstanding LSU.
// slave = LSU side; master = pipeline/bus-model side.
interface lsu_multi_outstanding_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [1:0]            req_dtype;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  flush;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_wr;
  logic [31:0]           rsp_rdata;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_err;
  logic                  rsp_misaligned;
  logic                  busy;
  logic                  data_req;
  logic                  data_wr;
  logic                  data_gnt;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic [3:0]            data_be;
  logic [31:0]           data_rdata;
  logic                  data_valid;
  logic                  data_error;

  modport slave (
    input  req_valid, req_wr, req_dtype, req_unsigned, req_addr, req_wdata, req_tag,
    input  flush, rsp_ready, data_gnt, data_rdata, data_valid, data_error,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_tag, rsp_err, rsp_misaligned,
    output busy, data_req, data_wr, data_addr, data_wdata, data_be
  );

  modport master (
    output req_valid, req_wr, req_dtype, req_unsigned, req_addr, req_wdata, req_tag,
    output flush, rsp_ready, data_gnt, data_rdata, data_valid, data_error,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_tag, rsp_err, rsp_misaligned,
    input  busy, data_req, data_wr, data_addr, data_wdata, data_be
  );
endinterface

// File: rtl/lsu_multi_outstanding.sv
// In-order LSU with DEPTH outstanding bus transactions; load response one cycle after data_valid.
// Backpressure: req_ready drops when full or flushing; rsp_ready low holds the head response stable.
module lsu_multi_outstanding #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lsu_multi_outstanding_if.slave  lsu
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [DEPTH-1:0]     r_wr, r_uns, r_done, r_err, r_mis, r_kill;
  logic [1:0]           r_dtype [DEPTH];
  logic [1:0]           r_off   [DEPTH];
  logic [TAG_WIDTH-1:0] r_tag   [DEPTH];
  logic [31:0]          r_rdata [DEPTH];
  ptr_t                 r_wptr, r_rptr, r_cptr;
  cnt_t                 r_cnt;
  cnt_t                 r_pend;  // entries from cptr up to wptr

  logic        w_mis, w_room, w_req, w_acc, w_dv, w_head_done, w_rsp_vld, w_pop;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_sh, w_ext, w_cap;
  logic [DEPTH-1:0] w_done_nxt;
  ptr_t        w_scan;
  cnt_t        w_rem;

  assign w_mis  = ((lsu.req_dtype == 2'd1) & lsu.req_addr[0]) |
                  (lsu.req_dtype[1] & (lsu.req_addr[1:0] != 2'b00));
  assign w_room = r_cnt < DEPTH_C;
  assign w_req  = lsu.req_valid & ~w_mis & ~lsu.flush & w_room;
  assign lsu.req_ready = ~lsu.flush & w_room & (w_mis | lsu.data_gnt);
  assign w_acc  = lsu.req_valid & lsu.req_ready;

  always_comb begin
    w_be = 4'b1111;
    w_wd = lsu.req_wdata;
    case (lsu.req_dtype)
      2'd0: begin
        w_be = 4'b0001 << lsu.req_addr[1:0];
        w_wd = {4{lsu.req_wdata[7:0]}};
      end
      2'd1: begin
        w_be = 4'b0011 << lsu.req_addr[1:0];
        w_wd = {2{lsu.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lsu.data_req   = w_req;
  assign lsu.data_wr    = w_req & lsu.req_wr;
  assign lsu.data_addr  = w_req ? {lsu.req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign lsu.data_wdata = w_req ? w_wd : 32'd0;
  assign lsu.data_be    = w_req ? w_be : 4'd0;

  // Beats with nothing granted outstanding (e.g. after reset) are dropped.
  assign w_dv = lsu.data_valid & (r_pend != '0);
  assign w_sh = lsu.data_rdata >> {r_off[r_cptr], 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_dtype[r_cptr])
      2'd0: w_ext = r_uns[r_cptr] ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
      2'd1: w_ext = r_uns[r_cptr] ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: ;
    endcase
    w_cap = (lsu.data_error | r_wr[r_cptr]) ? 32'd0 : w_ext;
  end

  // Move the capture pointer past the completed entry and any misaligned ones behind it.
  always_comb begin
    w_done_nxt = r_done;
    if (w_dv)  w_done_nxt[r_cptr] = 1'b1;
    if (w_acc) w_done_nxt[r_wptr] = w_mis;
    w_scan = w_dv ? r_cptr + 1'b1 : r_cptr;
    w_rem  = r_pend + cnt_t'(w_acc) - cnt_t'(w_dv);
    for (int i = 0; i < DEPTH; i++) begin
      if ((w_rem != '0) && w_done_nxt[w_scan]) begin
        w_scan = w_scan + 1'b1;
        w_rem  = w_rem - 1'b1;
      end
    end
  end

  assign w_head_done = (r_cnt != '0) & r_done[r_rptr];
  assign w_rsp_vld   = w_head_done & ~r_kill[r_rptr];
  assign w_pop       = w_head_done & (r_kill[r_rptr] | lsu.rsp_ready);

  assign lsu.rsp_valid      = w_rsp_vld;
  assign lsu.rsp_wr         = w_rsp_vld & r_wr[r_rptr];
  assign lsu.rsp_rdata      = w_rsp_vld ? r_rdata[r_rptr] : 32'd0;
  assign lsu.rsp_tag        = w_rsp_vld ? r_tag[r_rptr] : '0;
  assign lsu.rsp_err        = w_rsp_vld & r_err[r_rptr];
  assign lsu.rsp_misaligned = w_rsp_vld & r_mis[r_rptr];
  assign lsu.busy           = r_cnt != '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= '0;
      r_uns  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_mis  <= '0;
      r_kill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dtype[i] <= 2'd0;
        r_off[i]   <= 2'd0;
        r_tag[i]   <= '0;
        r_rdata[i] <= 32'd0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (lsu.flush) r_kill <= '1;
      if (w_dv) begin
        r_err[r_cptr]   <= lsu.data_error;
        r_rdata[r_cptr] <= w_cap;
      end
      if (w_acc) begin
        r_wr[r_wptr]    <= lsu.req_wr;
        r_uns[r_wptr]   <= lsu.req_unsigned;
        r_dtype[r_wptr] <= lsu.req_dtype;
        r_off[r_wptr]   <= lsu.req_addr[1:0];
        r_tag[r_wptr]   <= lsu.req_tag;
        r_err[r_wptr]   <= 1'b0;
        r_mis[r_wptr]   <= w_mis;
        r_kill[r_wptr]  <= 1'b0;
        r_rdata[r_wptr] <= 32'd0;
      end
      r_wptr <= r_wptr + ptr_t'(w_acc);
      r_rptr <= r_rptr + ptr_t'(w_pop);
      r_cptr <= w_scan;
      r_pend <= w_rem;
      r_cnt  <= r_cnt + cnt_t'(w_acc) - cnt_t'(w_pop);
    end
  end

  a_no_orphan_beat: assert property (@(posedge clk) disable iff (!reset_n)
                                     lsu.data_valid |-> (r_pend != '0));
endmodule
